clock_counters: RTL and testbench

CLOCK_COUNTERS -- requirements
Module: clock_counters

---
 rtl/clock_counters.sv | 100 ++++++++++
 tb/tb_clock_counters.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/clock_counters.sv
// 24-hour BCD time-of-day counter (HH:MM:SS) with a run mode driven by a
// seconds tick and a manual set mode that steps minutes and hours directly.
module clock_counters (
    input  logic       i_Clock,
    input  logic       i_Reset_Sec,
    input  logic       i_Enable_Increment,
    input  logic       i_Enable_Count_Sec,
    input  logic       i_Enable_Count_Min,
    input  logic       i_Enable_Count_Hour,
    output logic [3:0] o_Units_Sec,
    output logic [2:0] o_Tens_Sec,
    output logic [3:0] o_Units_Min,
    output logic [2:0] o_Tens_Min,
    output logic [3:0] o_Units_Hour,
    output logic [1:0] o_Tens_Hour
);

    // Declaration initialisers give the power-up value; minutes and hours
    // have no reset input, so this is the only way they start at zero.
    logic [3:0] r_units_sec  = 4'd0;
    logic [2:0] r_tens_sec   = 3'd0;
    logic [3:0] r_units_min  = 4'd0;
    logic [2:0] r_tens_min   = 3'd0;
    logic [3:0] r_units_hour = 4'd0;
    logic [1:0] r_tens_hour  = 2'd0;

    logic w_run_mode;
    logic w_sec_step;
    logic w_sec_at_max;
    logic w_sec_wrap;
    logic w_min_step;
    logic w_min_at_max;
    logic w_min_wrap;
    logic w_hour_step;
    logic w_hour_at_max;

    assign w_run_mode    = ~i_Enable_Increment;

    assign w_sec_step    = w_run_mode & i_Enable_Count_Sec & ~i_Reset_Sec;
    assign w_sec_at_max  = (r_units_sec == 4'd9) && (r_tens_sec == 3'd5);
    assign w_sec_wrap    = w_sec_step & w_sec_at_max;

    // In set mode minutes step on their own enable and never carry into hours.
    assign w_min_step    = i_Enable_Increment ? i_Enable_Count_Min
                                              : (w_sec_wrap & i_Enable_Count_Min);
    assign w_min_at_max  = (r_units_min == 4'd9) && (r_tens_min == 3'd5);
    assign w_min_wrap    = w_run_mode & w_min_step & w_min_at_max;

    assign w_hour_step   = i_Enable_Increment ? i_Enable_Count_Hour
                                              : (w_min_wrap & i_Enable_Count_Hour);
    assign w_hour_at_max = (r_units_hour == 4'd3) && (r_tens_hour == 2'd2);

    always_ff @(posedge i_Clock) begin
        if (i_Reset_Sec) begin
            r_units_sec <= 4'd0;
            r_tens_sec  <= 3'd0;
        end else if (w_sec_step) begin
            if (r_units_sec >= 4'd9) begin
                r_units_sec <= 4'd0;
                r_tens_sec  <= (r_tens_sec >= 3'd5) ? 3'd0 : r_tens_sec + 3'd1;
            end else begin
                r_units_sec <= r_units_sec + 4'd1;
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (w_min_step) begin
            if (r_units_min >= 4'd9) begin
                r_units_min <= 4'd0;
                r_tens_min  <= (r_tens_min >= 3'd5) ? 3'd0 : r_tens_min + 3'd1;
            end else begin
                r_units_min <= r_units_min + 4'd1;
            end
        end
    end

    // Hours roll 23->00 before the units 9->0 rule so 2x never passes 3.
    always_ff @(posedge i_Clock) begin
        if (w_hour_step) begin
            if (w_hour_at_max || (r_tens_hour > 2'd2)) begin
                r_units_hour <= 4'd0;
                r_tens_hour  <= 2'd0;
            end else if (r_units_hour >= 4'd9) begin
                r_units_hour <= 4'd0;
                r_tens_hour  <= r_tens_hour + 2'd1;
            end else begin
                r_units_hour <= r_units_hour + 4'd1;
            end
        end
    end

    assign o_Units_Sec  = r_units_sec;
    assign o_Tens_Sec   = r_tens_sec;
    assign o_Units_Min  = r_units_min;
    assign o_Tens_Min   = r_tens_min;
    assign o_Units_Hour = r_units_hour;
    assign o_Tens_Hour  = r_tens_hour;

endmodule

// File: tb/tb_clock_counters.sv
// Bench for clock_counters: an integer-seconds/minutes/hours model checked
// every cycle, plus literal HH:MM:SS checkpoints after each directed phase.
module tb_clock_counters;

    logic       clk;
    logic       r_rst;
    logic       r_inc;
    logic       r_es;
    logic       r_em;
    logic       r_eh;
    logic [3:0] w_us;
    logic [2:0] w_ts;
    logic [3:0] w_um;
    logic [2:0] w_tm;
    logic [3:0] w_uh;
    logic [1:0] w_th;

    int total = 0;
    int bad   = 0;
    int m_h   = 0;
    int m_m   = 0;
    int m_s   = 0;
    int cyc   = 0;

    clock_counters dut (
        .i_Clock            (clk),
        .i_Reset_Sec        (r_rst),
        .i_Enable_Increment (r_inc),
        .i_Enable_Count_Sec (r_es),
        .i_Enable_Count_Min (r_em),
        .i_Enable_Count_Hour(r_eh),
        .o_Units_Sec        (w_us),
        .o_Tens_Sec         (w_ts),
        .o_Units_Min        (w_um),
        .o_Tens_Min         (w_tm),
        .o_Units_Hour       (w_uh),
        .o_Tens_Hour        (w_th)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int dut_secs();
        return (int'(w_th) * 10 + int'(w_uh)) * 3600
             + (int'(w_tm) * 10 + int'(w_um)) * 60
             + (int'(w_ts) * 10 + int'(w_us));
    endfunction

    // Behavioural model: time as plain integers, following the mode rules.
    always @(posedge clk) begin
        if (r_inc) begin
            if (r_rst) m_s = 0;
            if (r_em)  m_m = (m_m + 1) % 60;
            if (r_eh)  m_h = (m_h + 1) % 24;
        end else if (r_rst) begin
            m_s = 0;
        end else if (r_es) begin
            if (m_s < 59) begin
                m_s = m_s + 1;
            end else begin
                m_s = 0;
                if (r_em) begin
                    if (m_m < 59) begin
                        m_m = m_m + 1;
                    end else begin
                        m_m = 0;
                        if (r_eh) m_h = (m_h + 1) % 24;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every digit against the model.
    always @(negedge clk) begin
        logic [19:0] act, exp_d;
        cyc++;
        act   = {w_th, w_uh, w_tm, w_um, w_ts, w_us};
        exp_d = {2'(m_h / 10), 4'(m_h % 10), 3'(m_m / 10), 4'(m_m % 10),
                 3'(m_s / 10), 4'(m_s % 10)};
        total++;
        if (act !== exp_d) begin
            bad++;
            if (bad < 20)
                $display("FAIL cycle%0d digits: got %h expected %h", cyc, act, exp_d);
        end
    end

    task automatic run(input int n, input logic inc, input logic rst,
                       input logic es, input logic em, input logic eh);
        r_inc = inc; r_rst = rst; r_es = es; r_em = em; r_eh = eh;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_lit(input string name, input int h, input int m, input int s);
        int want;
        int got;
        want = h * 3600 + m * 60 + s;
        got  = dut_secs();
        total += 2;
        if (got !== want || w_us > 4'd9 || w_um > 4'd9 || w_uh > 4'd9) begin
            bad++;
            $display("FAIL %s dut: got %0d%0d:%0d%0d:%0d%0d required %02d:%02d:%02d",
                     name, w_th, w_uh, w_tm, w_um, w_ts, w_us, h, m, s);
        end
        if ((m_h * 3600 + m_m * 60 + m_s) != want) begin
            bad++;
            $display("FAIL %s model: got %02d:%02d:%02d required %02d:%02d:%02d",
                     name, m_h, m_m, m_s, h, m, s);
        end
        $display("check %s: %0d%0d:%0d%0d:%0d%0d", name, w_th, w_uh, w_tm, w_um, w_ts, w_us);
    endtask

    initial begin
        r_rst = 0; r_inc = 0; r_es = 0; r_em = 0; r_eh = 0;
        run(5, 0, 0, 0, 0, 0);            check_lit("powerup", 0, 0, 0);
        run(1, 0, 1, 0, 0, 0);            check_lit("reset_pulse", 0, 0, 0);
        run(45296, 0, 0, 1, 1, 1);        check_lit("run_45296", 12, 34, 56);
        run(100, 0, 0, 0, 0, 0);          check_lit("hold_idle", 12, 34, 56);
        run(1, 0, 1, 0, 0, 0);            check_lit("reset_keeps_hm", 12, 34, 0);
        run(12, 1, 0, 0, 1, 1);           check_lit("set_both", 0, 46, 0);
        run(14, 1, 0, 0, 1, 0);           check_lit("set_min_wrap", 0, 0, 0);
        run(60, 0, 0, 1, 0, 1);           check_lit("en_min_low", 0, 0, 0);
        run(60, 0, 0, 1, 1, 1);           check_lit("en_min_high", 0, 1, 0);
        run(23, 1, 0, 1, 0, 1);           check_lit("set_hours_23", 23, 1, 0);
        run(58, 1, 0, 0, 1, 0);           check_lit("set_min_59", 23, 59, 0);
        run(59, 0, 0, 1, 1, 1);           check_lit("day_end", 23, 59, 59);
        run(1, 0, 0, 1, 1, 1);            check_lit("day_rollover", 0, 0, 0);
        run(30, 0, 0, 1, 0, 0);           check_lit("sec_30", 0, 0, 30);
        run(58, 1, 0, 1, 1, 0);           check_lit("set_0058", 0, 58, 30);
        run(2, 1, 0, 0, 1, 0);            check_lit("set_no_hour_carry", 0, 0, 30);
        run(19, 1, 0, 0, 0, 1);           check_lit("set_h19", 19, 0, 30);
        run(1, 1, 0, 0, 0, 1);            check_lit("set_h20", 20, 0, 30);
        run(4, 1, 0, 0, 0, 1);            check_lit("set_h24_wrap", 0, 0, 30);
        run(10, 1, 0, 0, 0, 1);           check_lit("set_h10", 10, 0, 30);
        run(1, 1, 1, 0, 1, 0);            check_lit("set_with_reset", 10, 1, 0);
        run(58, 1, 0, 0, 1, 0);           check_lit("set_1059", 10, 59, 0);
        run(59, 0, 0, 1, 1, 1);           check_lit("pre_reset", 10, 59, 59);
        run(1, 0, 1, 1, 1, 1);            check_lit("reset_tick_same", 10, 59, 0);
        run(3, 0, 1, 1, 1, 1);            check_lit("reset_held", 10, 59, 0);
        run(1, 0, 0, 1, 1, 1);            check_lit("resume", 10, 59, 1);
        run(2, 0, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
